// File: rtl/ping_arbiter.sv
// Round-robin arbiter that funnels one-shot ping captures from NUM_REQ level
// inputs into a single valid/ready byte-event port tagged with the source index.
module ping_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int SRC_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_in,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       en,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [SRC_W-1:0]           out_src,
  input  logic                       out_ready,
  output logic [NUM_REQ-1:0]         pending,
  output logic [NUM_REQ-1:0]         overrun,
  input  logic                       overrun_clr
);

  // state | meaning
  // IDLE  | no word presented; grant as soon as en and something is pending
  // HOLD  | out_valid high, data/src frozen until the sink accepts
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                   state;
  logic [NUM_REQ-1:0]       armed;
  logic [DATA_W-1:0]        cap_buf [NUM_REQ];
  logic [SRC_W-1:0]         rr_last;

  logic [NUM_REQ-1:0]       cap;
  logic [NUM_REQ-1:0]       gnt_oh;
  logic [NUM_REQ-1:0]       ovr_set;
  logic [SRC_W-1:0]         winner;
  logic                     found;
  logic                     xfer;
  logic                     grant;

  // Round-robin search starting just after the last winner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = (int'(rr_last) + k) % NUM_REQ;
      if (!found && pending[j]) begin
        found  = 1'b1;
        winner = SRC_W'(j);
      end
    end
  end

  always_comb begin
    xfer  = out_valid & out_ready;
    grant = en & found & ((state == S_IDLE) | ((state == S_HOLD) & xfer));
    cap   = req_in & armed;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_oh[i]  = grant && (winner == SRC_W'(i));
      ovr_set[i] = cap[i] && pending[i] && !gnt_oh[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= '0;
      pending <= '0;
      overrun <= '0;
      for (int i = 0; i < NUM_REQ; i++) cap_buf[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_in[i]) armed[i] <= 1'b1;
        else if (armed[i]) armed[i] <= 1'b0;

        // A capture on the cycle the channel is granted refills the slot.
        if (cap[i] && (!pending[i] || gnt_oh[i])) begin
          pending[i] <= 1'b1;
          cap_buf[i] <= req_data[i*DATA_W +: DATA_W];
        end else if (gnt_oh[i]) begin
          pending[i] <= 1'b0;
        end
      end
      overrun <= (overrun & {NUM_REQ{~overrun_clr}}) | ovr_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_last   <= SRC_W'(NUM_REQ - 1);
    end else begin
      if (grant) begin
        out_data  <= cap_buf[winner];
        out_src   <= winner;
        out_valid <= 1'b1;
        rr_last   <= winner;
        state     <= S_HOLD;
      end else if (state == S_HOLD && xfer) begin
        out_valid <= 1'b0;
        state     <= S_IDLE;
      end
    end
  end

endmodule
